// File: rtl/uart_pkg.sv
// Shared UART definitions: rx state encoding and oversampling constants.
// UART_RX_PARITY_EN adds the PARITY state to the rx state enum.
package uart_pkg;

  localparam int OVERSAMPLE   = 16;
  localparam int DBIT_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
`ifdef UART_RX_PARITY_EN
    , ST_PARITY
`endif
  } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line.
// Both flops reset to 1 so the idle-high line shows no false edge.
module uart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_q1;
  logic r_q2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q1 <= 1'b1;
      r_q2 <= 1'b1;
    end else begin
      r_q1 <= i_d;
      r_q2 <= r_q1;
    end
  end

  assign o_q = r_q2;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver with registered frame outputs.
// Define UART_RX_PARITY_EN to add an even-parity bit and parity_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEFAULT,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       rx,
  output logic       rx_done_tick,
  output logic [7:0] dout,
  output logic       frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

`ifdef UART_RX_PARITY_EN
  localparam rx_state_t AFTER_DATA = ST_PARITY;
`else
  localparam rx_state_t AFTER_DATA = ST_STOP;
`endif

  logic            w_rx;
  rx_state_t       r_state;
  logic [4:0]      r_s;
  logic [2:0]      r_n;
  logic [DBIT-1:0] r_b;
  logic [7:0]      r_dout;
  logic            r_done;
  logic            r_ferr;
  logic            r_armed;
`ifdef UART_RX_PARITY_EN
  logic            r_p;
  logic            r_perr;
`endif

  uart_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (rx),
    .o_q   (w_rx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
      r_armed <= 1'b1;
`ifdef UART_RX_PARITY_EN
      r_p     <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          // armed blocks a stuck-low line from retriggering after a break
          if (w_rx) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_state <= ST_START;
            r_s     <= '0;
          end
        end
        ST_START: begin
          if (s_tick) begin
            if (r_s == 5'(OVERSAMPLE / 2 - 1)) begin
              if (!w_rx) begin
                r_state <= ST_DATA;
                r_s     <= '0;
                r_n     <= '0;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_s <= r_s + 5'd1;
            end
          end
        end
        ST_DATA: begin
          if (s_tick) begin
            if (r_s == 5'(OVERSAMPLE - 1)) begin
              r_s <= '0;
              r_b <= {w_rx, r_b[DBIT-1:1]};
              if (r_n == 3'(DBIT - 1)) begin
                r_state <= AFTER_DATA;
              end else begin
                r_n <= r_n + 3'd1;
              end
            end else begin
              r_s <= r_s + 5'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (s_tick) begin
            if (r_s == 5'(OVERSAMPLE - 1)) begin
              r_s     <= '0;
              r_p     <= w_rx;
              r_state <= ST_STOP;
            end else begin
              r_s <= r_s + 5'd1;
            end
          end
        end
`endif
        ST_STOP: begin
          if (s_tick) begin
            if (r_s == 5'(SB_TICK - 1)) begin
              r_dout  <= 8'(r_b);
              r_ferr  <= ~w_rx;
              r_done  <= 1'b1;
              r_armed <= 1'b0;
              r_state <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
              r_perr  <= ^{r_b, r_p};
`endif
            end else begin
              r_s <= r_s + 5'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rx_done_tick = r_done;
  assign dout         = r_dout;
  assign frame_err    = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame table plus glitch/break/reset sequences.
// Define UART_RX_PARITY_EN to also exercise the parity bit.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       rx = 1'b1;
  logic       rx_done_tick;
  logic [7:0] dout;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int tcnt = 0;
  logic [7:0] q_d[$];

  uart_rx dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx           (rx),
    .rx_done_tick (rx_done_tick),
    .dout         (dout),
    .frame_err    (frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err   (parity_err)
`endif
  );

  always #5 clk = ~clk;

  // one s_tick every 4 clocks: 16 ticks per bit = 64 clocks
  always @(negedge clk) begin
    tcnt = (tcnt + 1) % 4;
    s_tick = (tcnt == 0);
  end

  always @(negedge clk) begin
    if (rx_done_tick) begin
      done_cnt++;
      q_d.push_back(dout);
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic line(input logic v, input int ticks);
    rx = v;
    repeat (ticks * 4) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] d, input logic p,
                       input logic stop);
    line(1'b0, 16);
    for (int i = 0; i < 8; i++) line(d[i], 16);
`ifdef UART_RX_PARITY_EN
    line(p, 16);
`endif
    line(stop, 16);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic [7:0] exp_d;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int c0;
    int idx;
    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 8'h3C, 1'b1};
    vecs[2] = '{8'h00, 1'b1, 8'h00, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
    vecs[4] = '{8'h81, 1'b0, 8'h81, 1'b1};

    repeat (5) @(negedge clk);
    chk("rst_done", {31'b0, rx_done_tick}, 0);
    chk("rst_dout", {24'b0, dout}, 0);
    chk("rst_fe", {31'b0, frame_err}, 0);
    reset = 1'b0;
    line(1'b1, 32);

    for (int k = 0; k < 5; k++) begin
      c0 = done_cnt;
      frame(vecs[k].d, ^vecs[k].d, vecs[k].stop);
      line(1'b1, 24);
      chk($sformatf("vec%0d_cnt", k), done_cnt - c0, 1);
      chk($sformatf("vec%0d_dout", k), {24'b0, dout}, {24'b0, vecs[k].exp_d});
      chk($sformatf("vec%0d_fe", k), {31'b0, frame_err},
          {31'b0, vecs[k].exp_fe});
`ifdef UART_RX_PARITY_EN
      chk($sformatf("vec%0d_pe", k), {31'b0, parity_err}, 0);
`endif
    end

    // short glitch is rejected, then a normal frame still works
    c0 = done_cnt;
    line(1'b0, 4);
    line(1'b1, 40);
    chk("glitch_cnt", done_cnt - c0, 0);
    frame(8'h69, 1'b0, 1'b1);
    line(1'b1, 24);
    chk("post_glitch_cnt", done_cnt - c0, 1);
    chk("post_glitch_dout", {24'b0, dout}, 32'h69);

    // bad stop bit then line stuck low: exactly one frame
    c0 = done_cnt;
    frame(8'h3C, 1'b0, 1'b0);
    line(1'b0, 16 * 25);
    chk("break_cnt", done_cnt - c0, 1);
    chk("break_dout", {24'b0, dout}, 32'h3C);
    chk("break_fe", {31'b0, frame_err}, 1);
    line(1'b1, 32);
    frame(8'h5A, 1'b0, 1'b1);
    line(1'b1, 24);
    chk("after_break_cnt", done_cnt - c0, 2);
    chk("after_break_dout", {24'b0, dout}, 32'h5A);
    chk("after_break_fe", {31'b0, frame_err}, 0);

    // back-to-back frames with no idle gap
    c0 = done_cnt;
    idx = q_d.size();
    frame(8'h55, 1'b0, 1'b1);
    frame(8'hAA, 1'b0, 1'b1);
    line(1'b1, 24);
    chk("b2b_cnt", done_cnt - c0, 2);
    if (q_d.size() >= idx + 2) begin
      chk("b2b_first", {24'b0, q_d[idx]}, 32'h55);
      chk("b2b_second", {24'b0, q_d[idx+1]}, 32'hAA);
    end else begin
      chk("b2b_queue", q_d.size(), idx + 2);
    end

    // reset in the middle of data bit 3 of 0xFF
    c0 = done_cnt;
    line(1'b0, 16);
    line(1'b1, 16 * 3 + 8);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_dout", {24'b0, dout}, 0);
    chk("midrst_fe", {31'b0, frame_err}, 0);
    reset = 1'b0;
    line(1'b1, 8 + 16 * 6);
    chk("midrst_cnt", done_cnt - c0, 0);
    chk("midrst_dout_hold", {24'b0, dout}, 0);
    frame(8'h12, 1'b0, 1'b1);
    line(1'b1, 24);
    chk("post_rst_cnt", done_cnt - c0, 1);
    chk("post_rst_dout", {24'b0, dout}, 32'h12);
    chk("post_rst_fe", {31'b0, frame_err}, 0);

`ifdef UART_RX_PARITY_EN
    frame(8'h07, 1'b0, 1'b1);
    line(1'b1, 24);
    chk("par0_pe", {31'b0, parity_err}, 1);
    chk("par0_dout", {24'b0, dout}, 32'h07);
    frame(8'h07, 1'b1, 1'b1);
    line(1'b1, 24);
    chk("par1_pe", {31'b0, parity_err}, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DBIT, default 8, number of data bits per frame (5-8).
REQ-002 SHALL have parameter SB_TICK, default 16, oversample ticks per stop bit (16 = 1 stop bit, 32 = 2 stop bits).
REQ-003 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port s_tick, input, 1, one-clk pulse at 16x baud from the baud generator.
REQ-006 SHALL have port rx, input, 1, asynchronous serial line; idles high.
REQ-007 SHALL have port rx_done_tick, output, 1, one-clk pulse when a frame completes; this is the write enable into the RX FIFO.
REQ-008 SHALL have port dout, output, 8, received byte, LSB-aligned; unused upper bits are 0 when DBIT<8.
REQ-009 SHALL have port frame_err, output, 1, stop-bit error flag for the frame just completed.

Function
REQ-010 SHALL pass rx through a two-flop synchronizer to form rx_sync; all decisions use rx_sync only.
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP (plus PARITY per REQ-024), with tick counter s (4 bits) and bit counter n (3 bits).
REQ-012 IDLE: SHALL go to START with s=0 when armed and rx_sync==0; s_tick is ignored in IDLE.
REQ-013 START: on each s_tick s SHALL increment; at s==7, if rx_sync==0 go to DATA with s=0, n=0, else return to IDLE (glitch rejection, no output).
REQ-014 DATA: on each s_tick s SHALL increment; at s==15, sample rx_sync into the shift register LSB-first and set s=0; at n==DBIT-1 go to STOP (or PARITY), else n increments.
REQ-015 STOP: on each s_tick s SHALL increment, with s 5 bits wide in STOP to allow SB_TICK=32; at s==SB_TICK-1, load dout, set frame_err=~rx_sync, and pulse rx_done_tick, then go to IDLE.
REQ-016 rx_done_tick, dout and frame_err SHALL be registered; all three update in the clk after the terminating s_tick, and dout/frame_err hold until the next rx_done_tick.
REQ-017 The armed flag SHALL clear on each rx_done_tick and set once rx_sync==1 is seen in IDLE, so a break (line stuck low) yields exactly one frame with frame_err=1 and dout=0x00.
REQ-018 Latency from the mid-stop-bit sample to rx_done_tick SHALL be exactly 1 clk; back-to-back frames with no idle gap SHALL be received.

Reset
REQ-019 Reset SHALL force the state to IDLE, s=0, n=0, the shift register to 0, dout=0x00, rx_done_tick=0, frame_err=0, armed=1, and both synchronizer flops to 1.
REQ-020 Reset asserted mid-frame SHALL abandon the frame with no rx_done_tick; reception restarts on the next falling edge after reset deasserts.
REQ-021 Reset SHALL take priority over s_tick in the same cycle.

Configuration
REQ-022 Macro UART_RX_PARITY_EN SHALL select the parity feature.
REQ-023 Without UART_RX_PARITY_EN: no parity state, no parity_err port, and the frame is start + DBIT + stop.
REQ-024 With UART_RX_PARITY_EN: a PARITY state SHALL sit between DATA and STOP and sample one bit at s==15; output port parity_err (1 bit) SHALL equal even-parity mismatch, update with rx_done_tick, and reset to 0.

Structure
REQ-025 Package uart_pkg SHALL hold the rx state enum, the OVERSAMPLE=16 constant, and the DBIT default shared with the transmitter and the top level.
REQ-026 The synchronizer SHALL be sub-module uart_sync2 (two flops, reset value 1); no other sub-modules.

Verification
REQ-027 Frame 0xA5, 16 ticks/bit, valid stop -> one rx_done_tick, dout=0xA5, frame_err=0.
REQ-028 rx low for 4 ticks then high -> no rx_done_tick, FSM back in IDLE.
REQ-029 Frame 0x3C with stop bit driven low -> dout=0x3C, frame_err=1; line then held low -> no further rx_done_tick until rx returns high.
REQ-030 Back-to-back frames 0x55 then 0xAA with no gap -> two rx_done_ticks, dout=0x55 then 0xAA.
REQ-031 Reset asserted at data bit 3 of 0xFF -> no rx_done_tick, outputs at reset values; a following 0x12 frame is received correctly.
REQ-032 With UART_RX_PARITY_EN: 0x07 with parity bit 0 -> parity_err=1; 0x07 with parity bit 1 -> parity_err=0.
